// File: rtl/mod_add_pkg.sv
// -----------------------------------------------------------------------------
// mod_add_pkg
// Shared definitions for the arbitrated modular adder (mod_add_arb) and its
// combinational datapath (mod_adder).
//   DEFAULT_BITWIDTH : default operand / modulus / result width
//   state_e          : output-register state, EMPTY (no result) / FULL (held)
// -----------------------------------------------------------------------------
package mod_add_pkg;

  localparam int DEFAULT_BITWIDTH = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : mod_add_pkg

// File: rtl/mod_adder.sv
// -----------------------------------------------------------------------------
// mod_adder
// Combinational modular adder: o_sum = (i_a + i_b) mod i_q for operands that
// are already reduced (i_a, i_b < i_q). The sum is formed at BITWIDTH+1 bits,
// so the carry is never lost, and a single conditional subtraction of i_q
// brings it back into range.
// Ports:
//   i_a, i_b : operands        (BITWIDTH)
//   i_q      : modulus         (BITWIDTH)
//   o_sum    : reduced sum     (BITWIDTH)
// -----------------------------------------------------------------------------
module mod_adder
  import mod_add_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] i_a,
  input  logic [BITWIDTH-1:0] i_b,
  input  logic [BITWIDTH-1:0] i_q,
  output logic [BITWIDTH-1:0] o_sum
);

  logic [BITWIDTH:0] w_sum;
  logic [BITWIDTH:0] w_q;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_q   = {1'b0, i_q};

  // With reduced operands the sum is below 2*i_q, so one subtraction suffices
  // and the result always fits back into BITWIDTH bits. Out-of-range operands
  // get the same single correction and nothing more.
  assign o_sum = BITWIDTH'((w_sum >= w_q) ? (w_sum - w_q) : w_sum);

endmodule : mod_adder

// File: rtl/mod_add_arb.sv
// -----------------------------------------------------------------------------
// mod_add_arb
// NUM_REQ requesters share one modular adder through a round-robin arbiter.
// A granted request is reduced mod iQ and captured in a single output
// register guarded by a two-state (EMPTY/FULL) valid/ready handshake that
// sustains one result per cycle with no bubble.
// Optional build macro MOD_ADD_ARB_RANGE_CHK_EN adds oErr, flagging accepted
// operands that are not below the modulus.
// Ports:
//   iClk, iRstN          : clock (rising edge), async active-low reset
//   iEn                  : grant enable
//   iClr                 : synchronous clear (drops held result, ptr -> 0)
//   iQ                   : modulus, held stable while oValid=1
//   iReqValid            : per-requester valid
//   oReqReady            : one-hot grant, combinational
//   iReqData0, iReqData1 : operands, requester i at [i*BITWIDTH +: BITWIDTH]
//   oValid, iReady       : result handshake
//   oData, oId           : (d0+d1) mod iQ and the granted requester index
//   oErr                 : operand range error (MOD_ADD_ARB_RANGE_CHK_EN only)
// -----------------------------------------------------------------------------
module mod_add_arb
  import mod_add_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int NUM_REQ  = 4
) (
  input  logic                          iClk,
  input  logic                          iRstN,
  input  logic                          iEn,
  input  logic                          iClr,
  input  logic [BITWIDTH-1:0]           iQ,
  input  logic [NUM_REQ-1:0]            iReqValid,
  output logic [NUM_REQ-1:0]            oReqReady,
  input  logic [NUM_REQ*BITWIDTH-1:0]   iReqData0,
  input  logic [NUM_REQ*BITWIDTH-1:0]   iReqData1,
  output logic                          oValid,
  input  logic                          iReady,
  output logic [BITWIDTH-1:0]           oData,
  output logic [$clog2(NUM_REQ)-1:0]    oId
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
  ,
  output logic                          oErr
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e              r_state;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_id;
  logic [BITWIDTH-1:0] r_data;

  logic                w_gnt_ok;
  logic                w_hit;
  logic                w_gnt;
  logic [IDW-1:0]      w_gnt_idx;
  logic [BITWIDTH-1:0] w_d0;
  logic [BITWIDTH-1:0] w_d1;
  logic [BITWIDTH-1:0] w_sum;

  // Wrap an index in [0, 2*NUM_REQ-2] back into [0, NUM_REQ-1].
  function automatic logic [IDW-1:0] wrap_idx(input int v);
    return IDW'((v >= NUM_REQ) ? (v - NUM_REQ) : v);
  endfunction

  // The output slot can take a new result when it is empty or being drained
  // this very cycle. Reset is folded in so oReqReady stays low while held.
  assign w_gnt_ok = iRstN && iEn && !iClr && (iQ != '0) &&
                    ((r_state == EMPTY) || iReady);

  // Round-robin search: first valid requester at or after r_ptr.
  // NOTE: every always_comb output gets a default before the loop so no path
  // leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    w_hit     = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && iReqValid[wrap_idx(int'(r_ptr) + k)]) begin
        w_hit     = 1'b1;
        w_gnt_idx = wrap_idx(int'(r_ptr) + k);
      end
    end
  end

  assign w_gnt     = w_gnt_ok && w_hit;
  assign oReqReady = w_gnt ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  assign w_d0 = iReqData0[w_gnt_idx*BITWIDTH +: BITWIDTH];
  assign w_d1 = iReqData1[w_gnt_idx*BITWIDTH +: BITWIDTH];

  mod_adder #(
    .BITWIDTH (BITWIDTH)
  ) u_mod_adder (
    .i_a   (w_d0),
    .i_b   (w_d1),
    .i_q   (iQ),
    .o_sum (w_sum)
  );

`ifdef MOD_ADD_ARB_RANGE_CHK_EN
  logic r_err;
  logic w_err;

  assign w_err = (w_d0 >= iQ) || (w_d1 >= iQ);
  assign oErr  = r_err;
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_id    <= '0;
      r_data  <= '0;
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
      r_err   <= 1'b0;
`endif
    end else if (iClr) begin
      // Clear outranks everything; w_gnt is already low here.
      r_state <= EMPTY;
      r_ptr   <= '0;
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        EMPTY: if (w_gnt) r_state <= FULL;
        FULL:  if (iReady && !w_gnt) r_state <= EMPTY;
      endcase

      if (w_gnt) begin
        r_data <= w_sum;
        r_id   <= w_gnt_idx;
        r_ptr  <= wrap_idx(int'(w_gnt_idx) + 1);
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
        r_err  <= w_err;
      end else if ((r_state == FULL) && iReady) begin
        r_err  <= 1'b0;
`endif
      end
    end
  end

  assign oValid = (r_state == FULL);
  assign oData  = r_data;
  assign oId    = r_id;

endmodule : mod_add_arb

// File: tb/tb_mod_add_arb.sv
// -----------------------------------------------------------------------------
// tb_mod_add_arb
// Self-checking bench for mod_add_arb (BITWIDTH=8, NUM_REQ=4). A reference
// model tracks the output slot and round-robin pointer from the behavioural
// rules, and a scoreboard queue holds every accepted request in grant order
// so each delivered result is matched exactly once.
// Build with MOD_ADD_ARB_RANGE_CHK_EN to also check oErr.
// -----------------------------------------------------------------------------
module tb_mod_add_arb;

  localparam int BW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic              ready;
  logic [BW-1:0]     q;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*BW-1:0]  req_d0;
  logic [NR*BW-1:0]  req_d1;
  logic              o_valid;
  logic [BW-1:0]     o_data;
  logic [IW-1:0]     o_id;
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
  logic              o_err;
`endif

  logic [BW-1:0] d0 [NR];
  logic [BW-1:0] d1 [NR];

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_d0[gi*BW +: BW] = d0[gi];
    assign req_d1[gi*BW +: BW] = d1[gi];
  end

  mod_add_arb #(
    .BITWIDTH (BW),
    .NUM_REQ  (NR)
  ) dut (
    .iClk      (clk),
    .iRstN     (rst_n),
    .iEn       (en),
    .iClr      (clr),
    .iQ        (q),
    .iReqValid (req_valid),
    .oReqReady (req_ready),
    .iReqData0 (req_d0),
    .iReqData1 (req_d1),
    .oValid    (o_valid),
    .iReady    (ready),
    .oData     (o_data),
    .oId       (o_id)
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
    ,
    .oErr      (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    bit err;
  } res_t;

  res_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model of the output slot and arbitration pointer.
  bit m_valid;
  int m_data;
  int m_id;
  bit m_err;
  int m_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 0;
    m_id    = 0;
    m_err   = 1'b0;
    m_ptr   = 0;
    sb.delete();
  endtask

  // One clock cycle. Called at a falling edge after inputs are driven.
  task automatic step();
    int            g;
    bit            gp;
    res_t          r;
    logic [NR-1:0] exp_rdy;
    #1;
    // Handshake of the currently held result: it must be the oldest accepted.
    if (o_valid === 1'b1 && ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(o_valid), 64'd0);
      end else begin
        r = sb.pop_front();
        check("sb_data", 64'(o_data), 64'(r.data));
        check("sb_id", 64'(o_id), 64'(r.id));
      end
    end
    gp = en && !clr && (q != 0) && (!m_valid || ready);
    g  = -1;
    if (gp) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("grant", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      r.id   = g;
      r.data = (int'(d0[g]) + int'(d1[g])) % int'(q);
      r.err  = (d0[g] >= q) || (d1[g] >= q);
      sb.push_back(r);
    end
    @(posedge clk);
    if (clr) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_err   = 1'b0;
      sb.delete();
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = r.data;
      m_id    = g;
      m_err   = r.err;
      m_ptr   = (g + 1) % NR;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
    @(negedge clk);
    check("valid", 64'(o_valid), 64'(m_valid));
    if (m_valid) begin
      check("data", 64'(o_data), 64'(m_data));
      check("id", 64'(o_id), 64'(m_id));
    end
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
    check("err", 64'(o_err), 64'(m_err));
`endif
  endtask

  int exp_g [5] = '{0, 1, 2, 3, 0};
  int exp_d [5] = '{22, 0, 1, 2, 22};

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    ready     = 1'b0;
    q         = '0;
    req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      d0[i] = '0;
      d1[i] = '0;
    end
    model_reset();

    // Reset values, with enable and requests active to show grants are held off.
    #3;
    en        = 1'b1;
    q         = BW'(23);
    req_valid = '1;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_id", 64'(o_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
`ifdef MOD_ADD_ARB_RANGE_CHK_EN
    check("rst_err", 64'(o_err), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round-robin over all requesters, back-to-back with iReady high.
    ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      d0[i] = BW'(i);
      d1[i] = BW'(22);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_data", 64'(o_data), 64'(exp_d[i]));
      check("rr_id", 64'(o_id), 64'(exp_g[i]));
    end

    // Backpressure: held result is stable, no grants, then no bubble.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_data", 64'(o_data), 64'd22);
      check("hold_id", 64'(o_id), 64'd0);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    ready = 1'b1;
    step();
    check("resume_id", 64'(o_id), 64'd1);
    check("resume_valid", 64'(o_valid), 64'd1);

    // Synchronous clear while full with requests pending.
    clr   = 1'b1;
    ready = 1'b0;
    step();
    check("clr_valid", 64'(o_valid), 64'd0);
    clr   = 1'b0;
    ready = 1'b1;
    step();
    check("clr_first_id", 64'(o_id), 64'd0);

    // Enable low: held result drains, nothing new is granted.
    en    = 1'b0;
    ready = 1'b0;
    repeat (2) step();
    ready = 1'b1;
    repeat (2) step();
    check("en_off_valid", 64'(o_valid), 64'd0);
    en = 1'b1;

    // Zero modulus: held result drains, grants stop until iQ returns.
    step();
    q = '0;
    repeat (6) step();
    check("q0_valid", 64'(o_valid), 64'd0);
    q = BW'(23);
    step();
    check("q_resume_id", 64'(o_id), 64'd2);
    check("q_resume_valid", 64'(o_valid), 64'd1);

    // Asynchronous reset in the middle of a stream.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_data", 64'(o_data), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_id", 64'(o_id), 64'd0);

`ifdef MOD_ADD_ARB_RANGE_CHK_EN
    // Operand equal to the modulus is flagged; result still reduced.
    req_valid = 4'b0001;
    d0[0]     = BW'(23);
    d1[0]     = BW'(1);
    step();
    check("range_err", 64'(o_err), 64'd1);
    check("range_data", 64'(o_data), 64'd1);
    d0[0] = BW'(5);
    step();
    check("range_ok_err", 64'(o_err), 64'd0);
    check("range_ok_data", 64'(o_data), 64'd6);
`endif

    // Drain before changing the modulus.
    req_valid = '0;
    ready     = 1'b1;
    repeat (2) step();

    // Randomized run against the model and scoreboard.
    q = BW'($urandom_range(2, 255));
    for (int c = 0; c < 1000; c++) begin
      req_valid = NR'($urandom);
      ready     = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < NR; i++) begin
        d0[i] = BW'($urandom_range(0, int'(q) - 1));
        d1[i] = BW'($urandom_range(0, int'(q) - 1));
      end
      step();
    end
    req_valid = '0;
    ready     = 1'b1;
    en        = 1'b1;
    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("final_valid", 64'(o_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mod_add_arb

// File: doc/mod_add_arb.md
MOD_ADD_ARB -- requirements
Module: mod_add_arb

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32: operand, modulus and result width.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one modular adder; legal values are 2 and greater.
REQ-003 SHALL have one clock, iClk; reset is iRstN, asynchronous and active-low.
REQ-004 SHALL list ports as name, direction, width, meaning, in this order:
- iClk, in, 1: clock, rising edge.
- iRstN, in, 1: async active-low reset.
- iEn, in, 1: grant enable.
- iClr, in, 1: synchronous clear.
- iQ, in, BITWIDTH: modulus; stable while oValid=1.
- iReqValid, in, NUM_REQ: per-requester valid.
- oReqReady, out, NUM_REQ: one-hot grant (combinational).
- iReqData0, in, NUM_REQ*BITWIDTH: operand 0; requester i at slice [i*BITWIDTH +: BITWIDTH].
- iReqData1, in, NUM_REQ*BITWIDTH: operand 1, same packing as iReqData0.
- oValid, out, 1: result valid.
- iReady, in, 1: downstream ready.
- oData, out, BITWIDTH: (d0+d1) mod iQ.
- oId, out, $clog2(NUM_REQ): index of the granted requester.

Function
REQ-005 SHALL hold one output register and a two-state FSM: EMPTY (oValid=0) and FULL (oValid=1).
REQ-006 SHALL assert grant-possible when iEn=1, iClr=0, iQ!=0, and either state is EMPTY or (FULL and iReady=1).
REQ-007 SHALL, when grant-possible, raise oReqReady for exactly one requester with iReqValid=1, chosen round-robin starting at pointer ptr; otherwise oReqReady SHALL be all zero.
REQ-008 SHALL move ptr to (granted index + 1) mod NUM_REQ on a grant; ptr SHALL be unchanged otherwise.
REQ-009 SHALL load the output register on the edge after a grant, with 1-cycle latency:
- oData = (d0+d1) mod iQ, with the sum computed at BITWIDTH+1 bits so it cannot overflow.
- oId = granted index.
REQ-010 SHALL follow these FSM transitions:
- EMPTY to FULL on a grant.
- FULL to FULL if iReady=0, or if iReady=1 and a grant occurs (back-to-back, no bubble).
- FULL to EMPTY if iReady=1 and there is no grant.
REQ-011 SHALL keep oData and oId stable while FULL and iReady=0.
REQ-012 SHALL make no grant while iQ=0; a result already held SHALL still drain normally.
REQ-013 SHALL, with iEn=0, make no new grants while the held result still drains.
REQ-014 SHALL treat iClr=1 as highest priority: next state EMPTY, oValid=0, ptr=0, no grant in that cycle, pending result discarded.
REQ-015 SHALL sustain one result per cycle when iReady=1 continuously and at least one request is pending.
REQ-016 SHALL treat requester operands >= iQ as a caller error; the result for them is (d0+d1) mod iQ as computed.

Reset
REQ-017 SHALL, while iRstN=0, force: state EMPTY, oValid=0, oData=0, oId=0, ptr=0, oErr=0 (when present), oReqReady=0.
REQ-018 SHALL discard any in-flight result if reset is asserted mid-operation; no output is produced after release until a new grant.

Configuration
REQ-019 SHALL, with MOD_ADD_ARB_RANGE_CHK_EN defined, add output oErr (1 bit), registered with oData. oErr=1 when the accepted d0>=iQ or d1>=iQ; it is held and cleared like oValid.
REQ-020 SHALL, without MOD_ADD_ARB_RANGE_CHK_EN, have no oErr port and no comparison logic.

Structure
REQ-021 SHALL place in shared package mod_add_pkg: the FSM state enum typedef (EMPTY, FULL) and the default BITWIDTH constant.
REQ-022 SHALL instance the existing combinational mod_adder exactly once on the muxed operands; round-robin selection SHALL stay inline.

Verification
REQ-023 SHALL cover: iQ=23, NUM_REQ=4, all valid, iReady=1, data i: (i, 22) -> grants 0,1,2,3,0 in consecutive cycles; oData 22,0,1,2,22; oId 0,1,2,3,0.
REQ-024 SHALL cover: FULL, iReady=0 for 5 cycles -> oReqReady=0, oData/oId constant; iReady=1 -> next grant in the same cycle, no bubble.
REQ-025 SHALL cover: iClr=1 while FULL with requests pending -> next cycle oValid=0, ptr=0; first grant after clear goes to requester 0.
REQ-026 SHALL cover: iQ=0 with requests pending -> oReqReady=0 indefinitely; iQ=23 -> grants resume.
REQ-027 SHALL cover: reset asserted mid-stream -> oValid=0 immediately; with MOD_ADD_ARB_RANGE_CHK_EN, operands (23,1), iQ=23 -> oErr=1, oData=1.
REQ-028 SHALL cover: randomized 1000-cycle run with an iReady pattern; every accepted request appears exactly once, in grant order, with oData == (d0+d1)%iQ.
